// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_det_pkg;

    typedef enum logic {
        UNCFG = 1'b0,
        HUNT  = 1'b1
    } seq_state_e;

    // Width needed to hold a length value in the range 0..pat_w
    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// rtl/seq_det_match.sv - masked compare of candidate history against the loaded pattern
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = calc_len_w(PAT_W)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [PAT_W-1:0] mask;

    // Only the low len bits take part; newest bit sits in bit 0 on both sides
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) mask[i] = 1'b1;
        end
        hit = (((hist ^ pat) & mask) == '0);
    end

endmodule

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - runtime-programmable serial sequence detector with match counter
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    parameter int LEN_W = calc_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seq_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err,
    output logic             armed
);

    seq_state_e       state_q, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic             ovl_q, ovl_n;
    logic [PAT_W-1:0] hist_q, hist_n;
    logic [LEN_W-1:0] fill_q, fill_n;
    logic             flag_n;
    logic [CNT_W-1:0] cnt_n;
    logic             err_n;

    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic             hit;
    logic             match;
    logic             cfg_legal;

    assign hist_shift = {hist_q[PAT_W-2:0], seq_in};
    assign fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    assign cfg_legal  = (cfg_len >= LEN_W'(1)) && (cfg_len <= LEN_W'(PAT_W));

    seq_det_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .hist (hist_shift),
        .pat  (pat_q),
        .len  (len_q),
        .hit  (hit)
    );

    // A match needs a qualified bit while hunting, no load in the way, and enough history
    assign match = (state_q == HUNT) && in_valid && !cfg_load && (fill_inc >= len_q) && hit;

    // Next-state: configuration load takes priority over incoming data
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        len_n   = len_q;
        ovl_n   = ovl_q;
        hist_n  = hist_q;
        fill_n  = fill_q;
        err_n   = cfg_err;
        flag_n  = 1'b0;
        cnt_n   = match_cnt;

        if (cfg_load) begin
            hist_n = '0;
            fill_n = '0;
            if (cfg_legal) begin
                pat_n   = cfg_pat;
                len_n   = cfg_len;
                ovl_n   = cfg_ovl;
                err_n   = 1'b0;
                state_n = HUNT;
            end else begin
                err_n   = 1'b1;
                state_n = UNCFG;
            end
        end else if (state_q == HUNT && in_valid) begin
            hist_n = hist_shift;
            fill_n = fill_inc;
            if (match) begin
                flag_n = 1'b1;
                // Without overlap, bits already consumed by this match must not be reused
                if (!ovl_q) fill_n = '0;
            end
        end

        if (cnt_clr) begin
            cnt_n = match ? CNT_W'(1) : '0;
        end else if (match && match_cnt != {CNT_W{1'b1}}) begin
            cnt_n = match_cnt + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNCFG;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            flag      <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_n;
            pat_q     <= pat_n;
            len_q     <= len_n;
            ovl_q     <= ovl_n;
            hist_q    <= hist_n;
            fill_q    <= fill_n;
            flag      <= flag_n;
            match_cnt <= cnt_n;
            cfg_err   <= err_n;
        end
    end

    assign armed = (state_q == HUNT);

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - randomized and directed bench for seq_det_param
module tb_seq_det_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             seq_in = 1'b0;
    logic             in_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_ovl = 1'b0;
    logic             cnt_clr = 1'b0;

    logic             flag, flag2;
    logic [15:0]      match_cnt;
    logic [1:0]       match_cnt2;
    logic             cfg_err, cfg_err2;
    logic             armed, armed2;

    int n_checks = 0;
    int n_fail   = 0;
    int nflag    = 0;
    int nflag2   = 0;

    // Reference model state
    bit     m_armed, m_err, m_flag, m_ovl;
    int     m_pat, m_len, m_cnt1, m_cnt2;
    bit     m_bits[$];

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(PAT_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .seq_in(seq_in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .flag(flag), .match_cnt(match_cnt), .cfg_err(cfg_err), .armed(armed)
    );

    seq_det_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .seq_in(seq_in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .flag(flag2), .match_cnt(match_cnt2), .cfg_err(cfg_err2), .armed(armed2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: keep the last PAT_W accepted bits, compare the tail as a number
    task automatic model_update();
        bit hit;
        int val;
        hit = 1'b0;
        if (rst) begin
            m_armed = 0; m_err = 0; m_flag = 0; m_ovl = 0;
            m_pat = 0; m_len = 0; m_cnt1 = 0; m_cnt2 = 0;
            m_bits.delete();
            return;
        end
        if (cfg_load) begin
            m_bits.delete();
            if (cfg_len >= 1 && cfg_len <= PAT_W) begin
                m_pat = int'(cfg_pat); m_len = int'(cfg_len); m_ovl = cfg_ovl;
                m_armed = 1; m_err = 0;
            end else begin
                m_armed = 0; m_err = 1;
            end
        end else if (m_armed && in_valid) begin
            m_bits.push_back(seq_in);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                val = 0;
                for (int k = 0; k < m_len; k++)
                    if (m_bits[m_bits.size() - 1 - k]) val = val + (1 << k);
                hit = (val == (m_pat & ((1 << m_len) - 1)));
            end
            if (hit && !m_ovl) m_bits.delete();
        end
        m_flag = hit;
        if (cnt_clr) begin
            m_cnt1 = hit ? 1 : 0;
            m_cnt2 = hit ? 1 : 0;
        end else if (hit) begin
            if (m_cnt1 < 65535) m_cnt1++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic cyc(input logic r, input logic ld, input logic v, input logic b, input logic clr);
        rst = r; cfg_load = ld; in_valid = v; seq_in = b; cnt_clr = clr;
        @(posedge clk);
        model_update();
        #1;
        check_val("flag", 32'(flag), 32'(m_flag));
        check_val("flag2", 32'(flag2), 32'(m_flag));
        check_val("cnt", 32'(match_cnt), 32'(m_cnt1));
        check_val("cnt2", 32'(match_cnt2), 32'(m_cnt2));
        check_val("cfg_err", 32'({cfg_err2, cfg_err}), 32'({m_err, m_err}));
        check_val("armed", 32'({armed2, armed}), 32'({m_armed, m_armed}));
        nflag  += int'(flag);
        nflag2 += int'(flag2);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pat = p; cfg_len = l; cfg_ovl = o;
        cyc(0, 1, 1, 1, 0);
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(0, 0, 1, bits[i], 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        check_val("rst_armed", 32'(armed), 32'd0);
        check_val("rst_cnt", 32'(match_cnt), 32'd0);

        // 1011010 with overlap: one flag
        load(8'h5A, 4'd7, 1'b1);
        nflag = 0;
        send(16'b1011010, 7);
        check_val("t1_flags", 32'(nflag), 32'd1);
        check_val("t1_cnt", 32'(match_cnt), 32'd1);

        // 12-bit stream, overlap then non-overlap
        cyc(0, 0, 0, 0, 1);
        load(8'h5A, 4'd7, 1'b1);
        nflag = 0;
        send(16'b101101011010, 12);
        check_val("t2_flags", 32'(nflag), 32'd2);
        check_val("t2_cnt", 32'(match_cnt), 32'd2);
        load(8'h5A, 4'd7, 1'b0);
        nflag = 0;
        send(16'b101101011010, 12);
        check_val("t2n_flags", 32'(nflag), 32'd1);
        check_val("t2n_cnt", 32'(match_cnt), 32'd3);

        // Qualification gap of three cycles
        load(8'h5A, 4'd7, 1'b1);
        nflag = 0;
        send(16'b1011, 4);
        repeat (3) cyc(0, 0, 0, 1, 0);
        send(16'b010, 3);
        check_val("t3_flags", 32'(nflag), 32'd1);

        // Illegal lengths
        load(8'h01, 4'd0, 1'b1);
        check_val("t4_err0", 32'(cfg_err), 32'd1);
        load(8'h01, 4'd9, 1'b1);
        check_val("t4_err9", 32'(cfg_err), 32'd1);
        check_val("t4_armed", 32'(armed), 32'd0);
        nflag = 0;
        send(16'hFFFF, 8);
        send(16'h5A5A, 16);
        check_val("t4_flags", 32'(nflag), 32'd0);
        load(8'h5A, 4'd7, 1'b1);
        check_val("t4_reload", 32'(cfg_err), 32'd0);

        // Reset mid-sequence
        send(16'b101101, 6);
        nflag = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_val("t5_flags", 32'(nflag), 32'd0);
        check_val("t5_armed", 32'(armed), 32'd0);
        check_val("t5_cnt", 32'(match_cnt), 32'd0);

        // Saturation on the narrow counter, back-to-back flags
        load(8'h01, 4'd1, 1'b1);
        nflag2 = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 1, 0);
            check_val("t6_flag_run", 32'(flag2), 32'd1);
        end
        check_val("t6_flags", 32'(nflag2), 32'd5);
        check_val("t6_sat", 32'(match_cnt2), 32'd3);
        cyc(0, 0, 1, 1, 1);
        check_val("t6_clr_hit", 32'(match_cnt2), 32'd1);

        // Randomized traffic
        load(8'h05, 4'd3, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic r, ld;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0);
            if (ld) begin
                cfg_pat = PAT_W'($urandom);
                cfg_len = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 9))
                                                      : LEN_W'($urandom_range(1, 3));
                cfg_ovl = 1'($urandom);
            end
            cyc(r, ld, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised, runtime-programmable serial sequence detector, successor to the fixed-pattern 1011010 detector. Samples one bit per qualified clock, compares the most recent `len` bits against a loaded pattern, and raises a one-cycle registered `flag` on each match. Adds overlap/non-overlap mode, input qualification, pattern load with error checking, and a saturating match counter. Sits between a serial bit source and control/status logic.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `CNT_W`, default 16: match counter width (≥1).
- `LEN_W`, default `$clog2(PAT_W+1)`: width of length fields. Derived; do not override.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `seq_in`  in  1  serial data bit.
- `in_valid`  in  1  `seq_in` is sampled only when high.
- `cfg_load`  in  1  latch `cfg_pat`, `cfg_len`, `cfg_ovl`.
- `cfg_pat`  in  PAT_W  pattern; first-received bit is `cfg_pat[cfg_len-1]`, last is `cfg_pat[0]`.
- `cfg_len`  in  LEN_W  pattern length, legal 1..PAT_W.
- `cfg_ovl`  in  1  1 = overlapping matches allowed.
- `cnt_clr`  in  1  clear match counter.
- `flag`  out  1  one-cycle match pulse.
- `match_cnt`  out  CNT_W  saturating match count.
- `cfg_err`  out  1  last load had illegal length.
- `armed`  out  1  a legal pattern is loaded.

## Operation
- Internal regs: `pat_q`, `len_q`, `ovl_q`, history shift register `hist` (PAT_W), fill counter `fill` (LEN_W, saturates at PAT_W).
- States: UNCFG (after reset or illegal load; `armed`=0, no matches) and HUNT (`armed`=1).
- `cfg_load`: if 1 ≤ `cfg_len` ≤ PAT_W → latch config, `cfg_err`=0, go HUNT; else `cfg_err`=1, go UNCFG. Either way `hist`, `fill`, `flag` clear next cycle. `match_cnt` untouched.
- HUNT, `in_valid`=1, no `cfg_load`: `hist_n = {hist[PAT_W-2:0], seq_in}`, `fill_n = min(fill+1, PAT_W)`. Match iff `fill_n ≥ len_q` and `hist_n[len_q-1:0] == pat_q[len_q-1:0]`.
- On match: `flag`=1 next cycle; `match_cnt` +1 (saturate at all-ones); if `ovl_q`=0, `fill` cleared to 0 (bits up to and including the match cannot contribute to the next match); if `ovl_q`=1, `fill` = `fill_n`.
- `in_valid`=0: `hist`, `fill` hold; `flag`=0.
- Priorities: `rst` > `cfg_load` > data. `cfg_load` with `in_valid` discards that bit.
- `cnt_clr` with simultaneous match → `match_cnt`=1; without match → 0.
- Reset: `flag`=0, `match_cnt`=0, `cfg_err`=0, `armed`=0, `pat_q`=0, `len_q`=0, `ovl_q`=0, `hist`=0, `fill`=0, state UNCFG. Reset mid-sequence discards partial history; config must be reloaded.

## Timing
- All outputs registered.
- Latency: bit completing a match sampled at edge N → `flag` high from edge N to N+1 exactly; `match_cnt` updated at edge N.
- Back-to-back matches (overlap, `len`=1) yield `flag` high on consecutive cycles.
- `armed`/`cfg_err` valid the cycle after `cfg_load`; first usable bit is the one sampled the edge after the load edge.

## Structure
- Package `seq_det_pkg`: state enum (UNCFG, HUNT), `LEN_W` helper function.
- Sub-module `seq_det_match`: combinational masked compare of `hist_n` vs `pat_q` under `len_q`, output `hit`. Top holds FSM, history, fill, counter.

## Test plan
- PAT_W=8, load pat=8'h5A, len=7, ovl=1; stream 1011010 → single `flag` after 7th bit, `match_cnt`=1.
- Same config, stream 101101011010 (12 bits) → flags after bits 7 and 12, `match_cnt`=2; reload with ovl=0, same stream → flag after bit 7 only, `match_cnt`=3.
- ovl=1, 1011010 with `in_valid` low for 3 cycles between bits 4 and 5 → one flag, delayed by 3 cycles.
- Load `cfg_len`=0 then `cfg_len`=9 → `cfg_err`=1, `armed`=0, no flag on any stream; legal reload clears `cfg_err`.
- Assert `rst` after 101101 then send 0 → no flag; `armed`=0, all outputs reset values.
- CNT_W=2, len=1, pat=1, ovl=1, five 1s → flag five consecutive cycles, `match_cnt` stops at 3; `cnt_clr` with a 1 on input → `match_cnt`=1.
